// File: rtl/pipelined_adder.sv
// Pipelined ripple-chunk adder/subtractor with valid/ready handshake.
// The operand is split into STAGES equal chunks; stage k adds chunk k using
// the carry registered by stage k-1, so results emerge STAGES edges after
// acceptance at a rate of one per cycle.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSTG = (STAGES < 1) ? 1 : STAGES;
    localparam int unsigned C    = WIDTH / NSTG;
    localparam int unsigned LAST = NSTG - 1;

    // Reject geometries that cannot be split into equal chunks
    generate
        if (STAGES < 1 || (WIDTH % NSTG) != 0) begin : g_bad_params
            $error("pipelined_adder: WIDTH must be a nonzero multiple of STAGES");
        end
    endgenerate

    // Per-stage state: valid, partial result, remaining operands, chunk carry
    logic             valid_q [NSTG];
    logic             valid_d [NSTG];
    logic [WIDTH-1:0] res_q   [NSTG];
    logic [WIDTH-1:0] res_d   [NSTG];
    logic             carry_q [NSTG];
    logic             carry_d [NSTG];
    logic [WIDTH-1:0] xop_q   [NSTG];
    logic [WIDTH-1:0] xop_d   [NSTG];
    logic [WIDTH-1:0] yop_q   [NSTG];
    logic [WIDTH-1:0] yop_d   [NSTG];
    logic             ovf_q;
    logic             ovf_d;
    logic             advance;

    // Whole pipeline moves together; a held result freezes every stage
    assign advance  = !valid_q[LAST] || out_ready;
    assign in_ready = advance;

    // Chunk adders: each stage consumes the low chunk of its operand copy and
    // passes the remaining chunks on shifted down by one chunk
    always_comb begin
        logic [WIDTH-1:0] xs;
        logic [WIDTH-1:0] ys;
        logic [WIDTH-1:0] rs;
        logic             cs;
        logic             vs;
        logic [C:0]       sum;

        xs    = '0;
        ys    = '0;
        rs    = '0;
        cs    = 1'b0;
        vs    = 1'b0;
        sum   = '0;
        ovf_d = 1'b0;
        for (int k = 0; k < int'(NSTG); k++) begin
            valid_d[k] = valid_q[k];
            res_d[k]   = res_q[k];
            carry_d[k] = carry_q[k];
            xop_d[k]   = xop_q[k];
            yop_d[k]   = yop_q[k];
        end

        for (int k = 0; k < int'(NSTG); k++) begin
            if (k == 0) begin
                xs = X;
                ys = sub ? ~Y : Y;
                rs = '0;
                cs = cin ^ sub;
                vs = in_valid;
            end else begin
                xs = xop_q[k-1];
                ys = yop_q[k-1];
                rs = res_q[k-1];
                cs = carry_q[k-1];
                vs = valid_q[k-1];
            end

            sum = {1'b0, xs[C-1:0]} + {1'b0, ys[C-1:0]} + {{C{1'b0}}, cs};

            valid_d[k]           = vs;
            res_d[k]             = rs;
            res_d[k][k*C +: C]   = sum[C-1:0];
            carry_d[k]           = sum[C];
            xop_d[k]             = xs >> C;
            yop_d[k]             = ys >> C;

            // Overflow only matters for the chunk holding the MSB
            if (k == int'(LAST)) begin
                ovf_d = sum[C] ^ (sum[C-1] ^ xs[C-1] ^ ys[C-1]);
            end
        end
    end

    // Stage registers with synchronous clear; hold everything on stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(NSTG); k++) begin
                valid_q[k] <= 1'b0;
                res_q[k]   <= '0;
                carry_q[k] <= 1'b0;
                xop_q[k]   <= '0;
                yop_q[k]   <= '0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < int'(NSTG); k++) begin
                valid_q[k] <= valid_d[k];
                res_q[k]   <= res_d[k];
                carry_q[k] <= carry_d[k];
                xop_q[k]   <= xop_d[k];
                yop_q[k]   <= yop_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = valid_q[LAST];
    assign S         = res_q[LAST];
    assign cout      = carry_q[LAST];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: directed vector table, backpressure and reset
// sequences, exhaustive 6-bit sweep and random 16-bit traffic against a
// plain-arithmetic reference model.
module tb_pipelined_adder;

    localparam int STAGES6 = 3;

    typedef struct {
        int x; int y; int cin; int sub;
        int s; int cout; int ovf;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        int          idx;
    } exp_t;

    logic clk;
    logic rst_n;

    logic       in_valid6, in_ready6, out_valid6, out_ready6, cin6, sub6, cout6, ovf6;
    logic [5:0] X6, Y6, S6;
    int         idx6;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, cin16, sub16, cout16, ovf16;
    logic [15:0] X16, Y16, S16;
    int          idx16;

    int total = 0;
    int bad   = 0;
    int deliv6 = 0;
    int deliv16 = 0;
    bit done16 = 0;

    exp_t q6[$];
    exp_t q16[$];
    vec_t vecs[10];

    pipelined_adder dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_ready(in_ready6),
        .X(X6), .Y(Y6), .cin(cin6), .sub(sub6), .out_valid(out_valid6),
        .out_ready(out_ready6), .S(S6), .cout(cout6), .ovf(ovf6)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .X(X16), .Y(Y16), .cin(cin16), .sub(sub16), .out_valid(out_valid16),
        .out_ready(out_ready16), .S(S16), .cout(cout16), .ovf(ovf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer add/subtract of unsigned and signed views
    function automatic exp_t model(input int w, input longint x, input longint y,
                                   input bit c, input bit sb, input int idx);
        exp_t   r;
        longint m, half, sx, sy, raw, sgn, ci;
        m    = longint'(1) << w;
        half = m / 2;
        ci   = c ? 1 : 0;
        sx   = (x >= half) ? x - m : x;
        sy   = (y >= half) ? y - m : y;
        if (!sb) begin
            raw    = x + y + ci;
            sgn    = sx + sy + ci;
            r.cout = (raw >= m);
        end else begin
            raw    = x - y - ci;
            sgn    = sx - sy - ci;
            r.cout = (raw >= 0);
            raw    = raw + m;
        end
        r.s   = 16'(raw % m);
        r.ovf = (sgn < -half) || (sgn >= half);
        r.idx = idx;
        return r;
    endfunction

    task automatic check(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Scoreboard for the 6-bit instance; a reset edge discards in-flight work
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q6.delete();
        end else begin
            if (out_valid6 && out_ready6) begin
                total++;
                deliv6++;
                if (q6.size() == 0) begin
                    bad++;
                    $display("FAIL out6_unexpected: S=%0d with nothing outstanding", S6);
                end else begin
                    e = q6.pop_front();
                    if (16'(S6) !== e.s || cout6 !== e.cout || ovf6 !== e.ovf) begin
                        bad++;
                        $display("FAIL out6 vec %0d: got S=%0d cout=%0b ovf=%0b, expected S=%0d cout=%0b ovf=%0b",
                                 e.idx, S6, cout6, ovf6, e.s, e.cout, e.ovf);
                    end
                end
            end
            if (in_valid6 && in_ready6)
                q6.push_back(model(6, longint'(X6), longint'(Y6), cin6, sub6, idx6));
        end
    end

    // Scoreboard for the 16-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q16.delete();
        end else begin
            if (out_valid16 && out_ready16) begin
                total++;
                deliv16++;
                if (q16.size() == 0) begin
                    bad++;
                    $display("FAIL out16_unexpected: S=%0d with nothing outstanding", S16);
                end else begin
                    e = q16.pop_front();
                    if (S16 !== e.s || cout16 !== e.cout || ovf16 !== e.ovf) begin
                        bad++;
                        $display("FAIL out16 vec %0d: got S=%0d cout=%0b ovf=%0b, expected S=%0d cout=%0b ovf=%0b",
                                 e.idx, S16, cout16, ovf16, e.s, e.cout, e.ovf);
                    end
                end
            end
            if (in_valid16 && in_ready16)
                q16.push_back(model(16, longint'(X16), longint'(Y16), cin16, sub16, idx16));
        end
    end

    // Present one transaction, hold until accepted, then scramble sub/cin
    task automatic send6(input int x, input int y, input int c, input int s, input int idx);
        int n;
        X6 = 6'(x); Y6 = 6'(y); cin6 = c[0]; sub6 = s[0]; idx6 = idx; in_valid6 = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready6 && n < 100);
        if (!in_ready6) begin
            total++; bad++;
            $display("FAIL send6_timeout vec %0d: in_ready stayed 0, expected 1", idx);
        end
        @(posedge clk); #1;
        in_valid6 = 1'b0; cin6 = 1'($urandom); sub6 = 1'($urandom); X6 = 6'($urandom);
    endtask

    task automatic send16(input int x, input int y, input int c, input int s, input int idx);
        int n;
        X16 = 16'(x); Y16 = 16'(y); cin16 = c[0]; sub16 = s[0]; idx16 = idx; in_valid16 = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready16 && n < 200);
        if (!in_ready16) begin
            total++; bad++;
            $display("FAIL send16_timeout vec %0d: in_ready stayed 0, expected 1", idx);
        end
        @(posedge clk); #1;
        in_valid16 = 1'b0; cin16 = 1'($urandom); sub16 = 1'($urandom);
    endtask

    task automatic wait_drain6(input string nm);
        for (int i = 0; i < 100 && q6.size() != 0; i++) @(negedge clk);
        check(nm, q6.size(), 0);
    endtask

    task automatic wait_drain16(input string nm);
        for (int i = 0; i < 400 && q16.size() != 0; i++) @(negedge clk);
        check(nm, q16.size(), 0);
    endtask

    // Single transaction on an idle pipe: latency and table values
    task automatic run_one(input vec_t v, input int i);
        int n;
        send6(v.x, v.y, v.cin, v.sub, 1000000 + i);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid6 && n < 20);
        check($sformatf("vec%0d_latency", i), n, STAGES6);
        check($sformatf("vec%0d_S", i), longint'(S6), v.s);
        check($sformatf("vec%0d_cout", i), longint'(cout6), v.cout);
        check($sformatf("vec%0d_ovf", i), longint'(ovf6), v.ovf);
        @(posedge clk); #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] held;
        int d0;
        vec_t v;

        //            x   y  cin sub   s  cout ovf
        vecs[0] = '{63,  1, 0, 0,  0, 1, 0};
        vecs[1] = '{31,  1, 0, 0, 32, 0, 1};
        vecs[2] = '{ 5,  7, 0, 1, 62, 0, 0};
        vecs[3] = '{ 7,  5, 0, 1,  2, 1, 0};
        vecs[4] = '{32,  1, 0, 1, 31, 1, 1};
        vecs[5] = '{ 0,  0, 1, 0,  1, 0, 0};
        vecs[6] = '{ 0,  0, 1, 1, 63, 0, 0};
        vecs[7] = '{63, 63, 1, 0, 63, 1, 0};
        vecs[8] = '{20, 12, 1, 1,  7, 1, 0};
        vecs[9] = '{31, 31, 1, 0, 63, 0, 1};

        rst_n = 1'b0;
        in_valid6 = 1'b1; X6 = 6'd9; Y6 = 6'd9; cin6 = 1'b1; sub6 = 1'b0; idx6 = -1; out_ready6 = 1'b1;
        in_valid16 = 1'b0; X16 = '0; Y16 = '0; cin16 = 1'b0; sub16 = 1'b0; idx16 = -1; out_ready16 = 1'b1;

        // Reset held two cycles with a pending input
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", longint'(out_valid6), 0);
        check("rst_S", longint'(S6), 0);
        check("rst_cout", longint'(cout6), 0);
        check("rst_ovf", longint'(ovf6), 0);
        check("rst_in_ready", longint'(in_ready6), 1);
        check("rst_out_valid16", longint'(out_valid16), 0);
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid6 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_idle%0d", i), longint'(out_valid6), 0);
        end
        @(posedge clk); #1;

        // Table of directed vectors
        for (int i = 0; i < 10; i++) run_one(vecs[i], i);

        // Backpressure: stall output during cycles 4 and 5
        d0 = deliv6;
        fork
            begin
                send6(10, 20, 0, 0, 2000);
                send6(40, 30, 1, 0, 2001);
                send6( 5,  9, 0, 1, 2002);
                send6(63,  0, 1, 0, 2003);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready6 = 1'b0;
                @(negedge clk);
                check("bp_in_ready_c4", longint'(in_ready6), 0);
                check("bp_out_valid_c4", longint'(out_valid6), 1);
                held = S6;
                @(posedge clk); #1;
                @(negedge clk);
                check("bp_in_ready_c5", longint'(in_ready6), 0);
                check("bp_S_stable", longint'(S6), longint'(held));
                @(posedge clk); #1;
                out_ready6 = 1'b1;
            end
        join
        wait_drain6("bp_drain");
        check("bp_count", deliv6 - d0, 4);

        // Reset with two transactions in flight
        @(posedge clk); #1;
        send6(1, 2, 0, 0, 3000);
        send6(3, 4, 0, 0, 3001);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        v = '{10, 20, 0, 0, 30, 0, 0};
        run_one(v, 10);

        // Exhaustive 6-bit sweep, back to back
        for (int x = 0; x < 64; x++)
            for (int y = 0; y < 64; y++)
                for (int s = 0; s < 2; s++)
                    for (int c = 0; c < 2; c++)
                        send6(x, y, c, s, ((x * 64 + y) * 2 + s) * 2 + c);
        wait_drain6("exh_drain");

        // Random 16-bit traffic with random output stalls
        d0 = deliv16;
        fork
            begin
                for (int i = 0; i < 1500; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send16(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), i);
                end
                done16 = 1'b1;
            end
            begin
                while (!done16) begin
                    @(posedge clk); #1;
                    out_ready16 = 1'($urandom_range(0, 1));
                end
                out_ready16 = 1'b1;
            end
        join
        wait_drain16("rnd16_drain");
        check("rnd16_count", deliv16 - d0, 1500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, operand and sum width in bits.
REQ-002 The block SHALL have parameter STAGES, default 3, pipeline depth and number of equal-width chunks.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand transaction present.
REQ-006 in_ready  output  1  block accepts a transaction this cycle.
REQ-007 X  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 Y  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in for add; borrow-in for subtract.
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 S  output  WIDTH  sum or difference.
REQ-014 cout  output  1  carry out of the MSB; in subtract mode 1 = no borrow.
REQ-015 ovf  output  1  signed overflow flag.

Function
REQ-016 Elaboration SHALL fail when WIDTH % STAGES != 0 or STAGES < 1; chunk width C = WIDTH/STAGES.
REQ-017 Effective operation SHALL be X + (sub ? ~Y : Y) + (sub ? ~cin : cin), computed modulo 2^WIDTH; cout is bit WIDTH of that sum.
REQ-018 ovf SHALL equal carry into MSB XOR carry out of MSB, from the same computation.
REQ-019 Stage k (k = 0..STAGES-1) SHALL add chunk k (bits k*C+C-1 .. k*C) of both operands with the registered carry of stage k-1; stage 0 uses the effective carry-in.
REQ-020 Each stage register SHALL hold: a valid bit, the result chunks computed so far, the unconsumed operand chunks (Y already conditionally inverted), and the chunk carry.
REQ-021 Latency SHALL be exactly STAGES cycles from the acceptance edge to out_valid=1 when not stalled; throughput 1 transaction per cycle.
REQ-022 Acceptance SHALL occur on a rising edge where in_valid=1 and in_ready=1; the result is delivered on an edge where out_valid=1 and out_ready=1.
REQ-023 Advance = !out_valid OR out_ready; in_ready SHALL equal advance (combinational from out_valid and out_ready only, not from in_valid).
REQ-024 On advance=1, every stage SHALL shift one position; stage 0 loads the input with valid = in_valid; bubbles propagate and are not collapsed.
REQ-025 On advance=0, all stage registers SHALL hold; S, cout, ovf, out_valid SHALL remain stable until accepted.
REQ-026 Simultaneous output acceptance and input acceptance in one cycle SHALL lose no transaction and duplicate none.
REQ-027 sub and cin SHALL be sampled at acceptance only; later changes do not affect in-flight transactions.
REQ-028 S, cout and ovf SHALL be driven from the final stage registers; their value while out_valid=0 is don't-care, except after reset.
REQ-029 Order of results SHALL equal order of acceptance.

Reset
REQ-030 With rst_n=0 at a rising edge, all stage valid bits, data, carries, S, cout, ovf and out_valid SHALL become 0.
REQ-031 During reset in_ready SHALL read 1 (out_valid=0) but no input is accepted; in-flight transactions are discarded without output.
REQ-032 The first acceptance SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-033 Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, S=0, cout=0, ovf=0, no result appears within 5 cycles after release without a new input.
REQ-034 Add wrap: WIDTH=6, STAGES=3, X=63, Y=1, cin=0, sub=0 -> after 3 cycles S=0, cout=1, ovf=0; X=31, Y=1 -> S=32, cout=0, ovf=1.
REQ-035 Subtract: X=5, Y=7, sub=1, cin=0 -> S=62, cout=0, ovf=0; X=7, Y=5 -> S=2, cout=1; X=32, Y=1 -> S=31, ovf=1.
REQ-036 Backpressure: 4 back-to-back inputs, out_ready=0 for cycles 4-5 -> in_ready=0 in those cycles, S stable, all 4 results delivered in order, none duplicated.
REQ-037 Reset mid-operation: assert rst_n=0 one cycle with 2 transactions in flight -> neither appears at output; a following transaction emerges after exactly 3 cycles.
REQ-038 Exhaustive: all 4096 X/Y pairs x sub x cin at WIDTH=6 plus random traffic at WIDTH=16, STAGES=4 with random out_ready -> zero mismatches against a behavioural reference model; error count and failing vector indices reported.
